// File: rtl/cc_deserializer.sv
// Assembles eight 64-bit MEM R-channel beats of a wrap burst into a 512-bit cache line.
// Optional protocol-error detection is built when CC_DESER_ERR_EN is defined.
module cc_deserializer #(
    parameter int unsigned BEATS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fill_start_i,
    input  logic [2:0]            fill_offset_i,
    input  logic [63:0]           mem_rdata_i,
    input  logic                  mem_rvalid_i,
    input  logic                  mem_rready_i,
    input  logic                  mem_rlast_i,
    output logic                  fill_valid_o,
    output logic [BEATS*64-1:0]   fill_line_o,
    input  logic                  fill_ready_i,
    output logic                  busy_o,
    output logic                  protocol_err_o
);

    localparam int unsigned WORD_W = 64;
    localparam int unsigned IDX_W  = 3;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_OUTPUT  = 2'd2;

    logic [1:0]                        r_state;
    logic [IDX_W-1:0]                  r_cnt;
    logic [IDX_W-1:0]                  r_offset;
    logic [BEATS-1:0][WORD_W-1:0]      r_line;
    logic                              r_fill_valid;

    logic [1:0]                        w_next_state;
    logic [IDX_W-1:0]                  w_next_cnt;
    logic [IDX_W-1:0]                  w_next_offset;
    logic [IDX_W-1:0]                  w_wr_idx;
    logic                              w_wr_en;
    logic                              w_beat;
    logic                              w_last_slot;
`ifdef CC_DESER_ERR_EN
    logic                              r_err;
    logic                              w_err_set;
`endif

    assign w_beat      = mem_rvalid_i & mem_rready_i;
    assign w_last_slot = (r_cnt == IDX_W'(BEATS - 1));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state, write-slot and counter decode
    always_comb begin
        w_next_state  = r_state;
        w_next_cnt    = r_cnt;
        w_next_offset = r_offset;
        w_wr_en       = 1'b0;
        w_wr_idx      = IDX_W'(r_offset + r_cnt);
`ifdef CC_DESER_ERR_EN
        w_err_set     = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (fill_start_i) begin
                    w_next_state  = ST_COLLECT;
                    w_next_offset = fill_offset_i;
                    w_next_cnt    = '0;
                    if (w_beat) begin
                        w_wr_en    = 1'b1;
                        w_wr_idx   = fill_offset_i;
                        w_next_cnt = IDX_W'(1);
`ifdef CC_DESER_ERR_EN
                        w_err_set  = mem_rlast_i;
`endif
                    end
                end else begin
`ifdef CC_DESER_ERR_EN
                    w_err_set = w_beat;
`endif
                end
            end
            ST_COLLECT: begin
                if (w_beat) begin
                    w_wr_en    = 1'b1;
                    w_next_cnt = IDX_W'(r_cnt + IDX_W'(1));
                    if (mem_rlast_i || w_last_slot) begin
                        w_next_state = ST_OUTPUT;
                    end
`ifdef CC_DESER_ERR_EN
                    w_err_set = (mem_rlast_i && !w_last_slot) || (w_last_slot && !mem_rlast_i);
`endif
                end
            end
            ST_OUTPUT: begin
                if (fill_ready_i) begin
                    w_next_state = ST_IDLE;
                end
`ifdef CC_DESER_ERR_EN
                w_err_set = w_beat;
`endif
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Line buffer, burst bookkeeping and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_offset     <= '0;
            r_line       <= '0;
            r_fill_valid <= 1'b0;
        end else begin
            r_cnt        <= w_next_cnt;
            r_offset     <= w_next_offset;
            r_fill_valid <= (w_next_state == ST_OUTPUT);
            if (w_wr_en) begin
                r_line[w_wr_idx] <= mem_rdata_i;
            end
        end
    end

`ifdef CC_DESER_ERR_EN
    // Sticky until reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end
    end
    assign protocol_err_o = r_err;
`else
    assign protocol_err_o = 1'b0;
`endif

    assign fill_valid_o = r_fill_valid;
    assign fill_line_o  = r_line;
    assign busy_o       = (r_state != ST_IDLE);

endmodule
